csa_pipe_addsub: RTL

//  Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16b CSA.

---
 rtl/csa_pipe_addsub.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/csa_pipe_addsub.sv
// Pipelined, parametrised carry-select adder/subtractor with valid/ready on both sides.
// Each pipeline stage resolves BLKS_PER_STAGE carry-select blocks; the carry between
// stages is registered, operands travel with the op (input skew) and already-resolved
// result slices travel with it too (output deskew), so S leaves coherent.
module csa_pipe_addsub #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BLK            = 4,
    parameter int unsigned BLKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SW     = BLK * BLKS_PER_STAGE;
    localparam int unsigned NSTAGE = (WIDTH + SW - 1) / SW;

    // Refuse to elaborate when the width does not split into whole blocks.
    if ((BLK == 0) || (BLKS_PER_STAGE == 0) || ((WIDTH % BLK) != 0)) begin : g_bad_cfg
        $error("csa_pipe_addsub: WIDTH must be a non-zero multiple of BLK");
    end

    // Per-stage pipeline registers: operands, partial sum, carry out, valid.
    logic [WIDTH-1:0]  a_q [NSTAGE];
    logic [WIDTH-1:0]  a_d [NSTAGE];
    logic [WIDTH-1:0]  b_q [NSTAGE];
    logic [WIDTH-1:0]  b_d [NSTAGE];
    logic [WIDTH-1:0]  s_q [NSTAGE];
    logic [WIDTH-1:0]  s_d [NSTAGE];
    logic [NSTAGE-1:0] c_q;
    logic [NSTAGE-1:0] c_d;
    logic [NSTAGE-1:0] v_q;
    logic [NSTAGE-1:0] v_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;

    // Stage inputs (from the ports for stage 0, from the previous register otherwise).
    logic [WIDTH-1:0]  src_a [NSTAGE];
    logic [WIDTH-1:0]  src_b [NSTAGE];
    logic [WIDTH-1:0]  src_s [NSTAGE];
    logic [NSTAGE-1:0] src_c;
    logic [NSTAGE-1:0] src_v;

    // Stage results before the register.
    logic [WIDTH-1:0]  res_s [NSTAGE];
    logic [NSTAGE-1:0] res_c;

    logic              stall_c;

    // A result waiting on the consumer freezes the whole pipe.
    assign stall_c  = v_q[NSTAGE-1] & ~out_ready;
    assign in_ready = ~stall_c;

    // Route operands into each stage; subtraction inverts B and forces carry-in.
    always_comb begin
        src_a    = '{default: '0};
        src_b    = '{default: '0};
        src_s    = '{default: '0};
        src_c    = '0;
        src_v    = '0;
        src_a[0] = A;
        src_b[0] = sub ? ~B : B;
        src_s[0] = '0;
        src_c[0] = sub | Cin;
        src_v[0] = in_valid;
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    // Carry-select blocks: both candidate sums per block, incoming carry picks one.
    always_comb begin
        logic [WIDTH-1:0] part_s;
        logic             cy;
        logic [BLK:0]     sum0;
        logic [BLK:0]     sum1;
        int unsigned      lo;
        res_s  = '{default: '0};
        res_c  = '0;
        part_s = '0;
        cy     = 1'b0;
        sum0   = '0;
        sum1   = '0;
        lo     = 0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            part_s = src_s[k];
            cy     = src_c[k];
            for (int unsigned j = 0; j < BLKS_PER_STAGE; j++) begin
                lo = (k * SW) + (j * BLK);
                if (lo < WIDTH) begin
                    sum0 = {1'b0, src_a[k][lo +: BLK]} + {1'b0, src_b[k][lo +: BLK]};
                    sum1 = {1'b0, src_a[k][lo +: BLK]} + {1'b0, src_b[k][lo +: BLK]}
                         + {{BLK{1'b0}}, 1'b1};
                    part_s[lo +: BLK] = cy ? sum1[BLK-1:0] : sum0[BLK-1:0];
                    cy                = cy ? sum1[BLK]     : sum0[BLK];
                end
            end
            res_s[k] = part_s;
            res_c[k] = cy;
        end
    end

    // Next-state: advance every stage unless stalled; flags come from the last stage.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        c_d    = c_q;
        v_d    = v_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (!stall_c) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                a_d[k] = src_a[k];
                b_d[k] = src_b[k];
                s_d[k] = res_s[k];
                c_d[k] = res_c[k];
                v_d[k] = src_v[k];
            end
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            ovf_d  = res_c[NSTAGE-1] ^ (res_s[NSTAGE-1][WIDTH-1]
                   ^ src_a[NSTAGE-1][WIDTH-1] ^ src_b[NSTAGE-1][WIDTH-1]);
            zero_d = ~|res_s[NSTAGE-1];
        end
    end

    // Pipeline registers with synchronous reset; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            s_q    <= '{default: '0};
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[NSTAGE-1];
    assign S         = s_q[NSTAGE-1];
    assign Cout      = c_q[NSTAGE-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
